obi_scratchpad_responder: RTL and testbench
===========================================

# obi_scratchpad_responder

OBI slave (responder) with a local word-addressed scratchpad memory. It serves the external-master side of the SoC, where the CGRA masters and X-HEEP act as initiators, and gives them a deterministic memory target. The block has a programmable number of grant wait-states and a fixed read/write response latency. Accesses outside its address window complete normally but return an error pattern and increment an error counter.

## Interface
- BASE_ADDR, 32'h0000_0000: byte base address of the window; must be 4-byte aligned.
- NUM_WORDS, 1024: number of 32-bit words; power of two, at least 2.
- LATENCY, 1: cycles from the grant cycle to `rvalid`; legal range 1..4.
- GNT_WAIT, 0: wait-state cycles inserted before each grant; legal range 0..3.
- clk_i  input  1  clock; all logic is rising-edge.
- rst_i  input  1  reset; asynchronous and active-high.
- obi_req_i  input  obi_req_t  fields used: `req`, `we`, `be[3:0]`, `addr[31:0]`, `wdata[31:0]`.
- obi_resp_o  output  obi_resp_t  fields driven: `gnt`, `rvalid`, `rdata[31:0]`.
- err_count_o  output  16  saturating count of out-of-window accesses.
- busy_o  output  1  high while a request is pending or any response is in flight.

## Operation
- Address decode:
  - A request is in-window when `BASE_ADDR <= addr < BASE_ADDR + 4*NUM_WORDS`.
  - Word index is `(addr - BASE_ADDR) >> 2`.
  - `addr[1:0]` is ignored.
- Grant FSM. States are IDLE and WAIT, with a wait counter `wcnt` of 2 bits.
  - GNT_WAIT=0: `gnt = req` combinationally. The FSM stays in IDLE.
  - GNT_WAIT>0, in IDLE: when `req` rises, load `wcnt=GNT_WAIT-1` and go to WAIT. `gnt` stays 0.
  - In WAIT: if `wcnt==0`, assert `gnt` this cycle and go to IDLE; otherwise decrement `wcnt`.
  - Back-to-back requests: every request pays GNT_WAIT cycles before its grant.
  - The initiator holds the request stable until `gnt`. If `req` drops while in WAIT, the FSM returns to IDLE with no grant; this is tolerated, not an error.
- Grant cycle (`req && gnt`):
  - In-window write: update each byte `i` with `be[i]=1` at the clock edge.
  - Read: sample the memory word.
  - Either way, push one entry `{valid, rdata}` into the response pipe.
  - Write responses carry `rdata=0`.
- Out-of-window access:
  - The request is granted and responded to normally.
  - A write has no memory effect.
  - A read returns `ERR_RDATA = 32'hBADC_AB1E`.
  - `err_count_o` increments by 1 per granted out-of-window access and saturates at 16'hFFFF.
- Read-after-write: a read granted in the cycle after a write to the same word returns the new data.
- Memory contents are not reset.

## Timing
- Reset values:
  - `gnt` is 0 and is forced to 0 while `rst_i` is high, including the combinational case.
  - `rvalid` 0, `rdata` 32'h0, `err_count_o` 0, `busy_o` 0.
  - FSM in IDLE, `wcnt` 0.
- Response timing:
  - `rvalid` is high for exactly one cycle, LATENCY cycles after the grant cycle.
  - A grant in cycle t gives `rvalid` in cycle t+LATENCY.
  - Responses return in grant order.
- Throughput:
  - GNT_WAIT=0: one grant per cycle, so up to LATENCY responses are outstanding.
  - Otherwise: one grant per GNT_WAIT+1 cycles.
- `rdata` is only meaningful while `rvalid=1`. Outside that it holds 0.
- There is no backpressure on responses: the initiator must accept `rvalid` when it arrives.
- `busy_o` = `req` OR (any pipe stage valid).
- Reset mid-operation: all in-flight responses are dropped (no late `rvalid`), and the FSM returns to IDLE. Writes already committed to memory remain.
- `err_count_o` updates at the grant edge, so it is visible in cycle t+1.

## Structure
- Types: `obi_req_t` and `obi_resp_t` come from `obi_pkg`.
- Shared constants go in `soc_sonhamos_pkg`:
  - `ERR_RDATA`.
  - The scratchpad's BASE_ADDR and NUM_WORDS, alongside the `EXT_XBAR_ADDR_RULES` entry for this window.
- Sub-module `obi_resp_pipe #(LATENCY)`: a shift register of `{valid, rdata[31:0]}` entries with asynchronous active-high clear of the valid bits. The top module holds the FSM, the decode, the memory array and the counter.

## Test plan
- GNT_WAIT=0, LATENCY=1:
  - Write 32'hDEAD_BEEF to BASE+0x10 with be=4'hF, then read BASE+0x10 in the next cycle.
  - Required: `gnt` same-cycle for both requests; the read's `rvalid` one cycle after its grant with `rdata` 32'hDEAD_BEEF.
- Byte enables:
  - Write 32'h1122_3344 with be=4'hF, then write 32'hAABB_CCDD with be=4'b0101, then read.
  - Required: read returns 32'h11BB_33DD.
- GNT_WAIT=2, LATENCY=3:
  - Hold `req` for a read.
  - Required: `gnt` in the 3rd request cycle and `rvalid` exactly 3 cycles after that.
  - Drop `req` in WAIT: required no `gnt` and no `rvalid`.
- GNT_WAIT=0, LATENCY=4:
  - Issue 4 back-to-back reads of words 0..3, preloaded with values 0..3.
  - Required: 4 consecutive `rvalid` cycles returning 0, 1, 2, 3; `busy_o` high throughout, then low.
- Out-of-window:
  - Read BASE+4*NUM_WORDS. Required: `rdata` 32'hBADC_AB1E and `err_count_o`=1.
  - Write out of window. Required: memory unchanged.
  - Force the counter to 16'hFFFF and issue another out-of-window access. Required: it stays at 16'hFFFF.
- Reset mid-flight:
  - LATENCY=3: assert `rst_i` one cycle after a read grant.
  - Required: no `rvalid` afterward, all outputs at their reset values, and previously written data still readable after reset.

Source files
------------

// File: rtl/obi_pkg.sv
// obi_pkg: OBI request/response bundles shared by initiators and responders
package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

// File: rtl/soc_sonhamos_pkg.sv
// soc_sonhamos_pkg: SoC-level constants, external crossbar map and scratchpad types
package soc_sonhamos_pkg;
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_rule_t;
  typedef enum logic {ST_IDLE, ST_WAIT} gnt_state_e;
  localparam logic [31:0] ERR_RDATA = 32'hBADC_AB1E;
  localparam logic [31:0] SPM_BASE_ADDR = 32'h0000_0000;
  localparam int unsigned SPM_NUM_WORDS = 1024;
  localparam addr_rule_t EXT_XBAR_ADDR_RULES [1] = '{
    '{idx: 32'd0, start_addr: SPM_BASE_ADDR, end_addr: SPM_BASE_ADDR + 32'(4 * SPM_NUM_WORDS)}
  };
endpackage

// File: rtl/obi_resp_pipe.sv
// obi_resp_pipe: fixed-latency shift register of {valid, rdata} response entries
module obi_resp_pipe #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        out_valid_o,
  output logic [31:0] out_data_o,
  output logic        busy_o
);
  logic [LATENCY-1:0] valid_q, valid_d;
  logic [31:0] data_q [LATENCY];
  logic [31:0] data_d [LATENCY];
  always_comb begin
    valid_d = LATENCY'({valid_q, in_valid_i});
    data_d = data_q;
    data_d[0] = in_data_i;
    for (int i = 1; i < LATENCY; i++) data_d[i] = data_q[i-1];
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) valid_q <= '0;
    else valid_q <= valid_d;
  // payload needs no reset: it is masked by the valid bit on the way out
  always_ff @(posedge clk_i) data_q <= data_d;
  assign out_valid_o = valid_q[LATENCY-1];
  assign out_data_o = out_valid_o ? data_q[LATENCY-1] : '0;
  assign busy_o = |valid_q;
endmodule

// File: rtl/obi_scratchpad_responder.sv
// obi_scratchpad_responder: OBI responder over a word-addressed scratchpad with
// programmable grant wait-states, fixed response latency and out-of-window error count
module obi_scratchpad_responder
  import obi_pkg::*;
  import soc_sonhamos_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = SPM_BASE_ADDR,
  parameter int unsigned NUM_WORDS = SPM_NUM_WORDS,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned GNT_WAIT = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  obi_req_t    obi_req_i,
  output obi_resp_t   obi_resp_o,
  output logic [15:0] err_count_o,
  output logic        busy_o
);
  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(4 * NUM_WORDS);
  gnt_state_e state_q, state_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] mem_q [NUM_WORDS];
  logic [31:0] off, push_data, rdata;
  logic [AW-1:0] idx;
  logic in_win, gnt, rvalid, pipe_busy;
  assign off = obi_req_i.addr - BASE_ADDR;
  assign idx = off[AW+1:2];
  assign in_win = (obi_req_i.addr >= BASE_ADDR) && (off < WIN_BYTES);
  // with no wait-states the FSM never leaves idle and grant is purely combinational
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    gnt = 1'b0;
    if (GNT_WAIT == 0) gnt = obi_req_i.req;
    else if (state_q == ST_IDLE) begin
      if (obi_req_i.req) begin
        state_d = ST_WAIT;
        wcnt_d = 2'(GNT_WAIT - 1);
      end
    end else if (!obi_req_i.req) state_d = ST_IDLE;
    else if (wcnt_q == 2'd0) begin
      gnt = 1'b1;
      state_d = ST_IDLE;
    end else wcnt_d = wcnt_q - 2'd1;
    gnt = gnt && !rst_i;
    err_count_d = (gnt && !in_win && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
    push_data = obi_req_i.we ? '0 : in_win ? mem_q[idx] : ERR_RDATA;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= ST_IDLE;
      wcnt_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      err_count_q <= err_count_d;
    end
  always_ff @(posedge clk_i)
    if (gnt && obi_req_i.we && in_win)
      for (int i = 0; i < 4; i++)
        if (obi_req_i.be[i]) mem_q[idx][8*i +: 8] <= obi_req_i.wdata[8*i +: 8];
  obi_resp_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (gnt),
    .in_data_i  (push_data),
    .out_valid_o(rvalid),
    .out_data_o (rdata),
    .busy_o     (pipe_busy)
  );
  assign obi_resp_o = '{gnt: gnt, rvalid: rvalid, rdata: rdata};
  assign err_count_o = err_count_q;
  assign busy_o = !rst_i && (obi_req_i.req || pipe_busy);
endmodule

// File: tb/tb_obi_scratchpad_responder.sv
// tb_obi_scratchpad_responder: directed checks over three responder configurations
module tb_obi_scratchpad_responder;
  import obi_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  obi_req_t r0, r1, r2;
  obi_resp_t p0, p1, p2;
  logic [15:0] e0, e1, e2;
  logic b0, b1, b2;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  obi_scratchpad_responder #(.LATENCY(1), .GNT_WAIT(0)) u0 (
    .clk_i(clk), .rst_i(rst), .obi_req_i(r0), .obi_resp_o(p0), .err_count_o(e0), .busy_o(b0));
  obi_scratchpad_responder #(.LATENCY(3), .GNT_WAIT(2)) u1 (
    .clk_i(clk), .rst_i(rst), .obi_req_i(r1), .obi_resp_o(p1), .err_count_o(e1), .busy_o(b1));
  obi_scratchpad_responder #(.LATENCY(4), .GNT_WAIT(0)) u2 (
    .clk_i(clk), .rst_i(rst), .obi_req_i(r2), .obi_resp_o(p2), .err_count_o(e2), .busy_o(b2));

  function automatic obi_req_t rq(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    rq = '{req: 1'b1, we: we, be: be, addr: a, wdata: d};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    r0 = rq(1'b0, 4'hF, 32'h10, 32'h0);
    r1 = '0;
    r2 = '0;
    rst = 1'b1;
    mid();
    n_cmp++; if (p0.gnt !== 1'b0) begin n_bad++; $display("FAIL rst_gnt: got %b want 0", p0.gnt); end
    n_cmp++; if (p0.rvalid !== 1'b0 || p1.rvalid !== 1'b0 || p2.rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %b%b%b want 000", p0.rvalid, p1.rvalid, p2.rvalid); end
    n_cmp++; if (p0.rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", p0.rdata); end
    n_cmp++; if (e0 !== 16'h0 || e1 !== 16'h0) begin n_bad++; $display("FAIL rst_err: got %h/%h want 0", e0, e1); end
    n_cmp++; if (b0 !== 1'b0 || b1 !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b%b want 00", b0, b1); end
    step();
    r0 = '0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    r0 = rq(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    mid();
    n_cmp++; if (p0.gnt !== 1'b1) begin n_bad++; $display("FAIL wr_gnt: got %b want 1", p0.gnt); end
    n_cmp++; if (b0 !== 1'b1) begin n_bad++; $display("FAIL wr_busy: got %b want 1", b0); end
    step();
    r0 = rq(1'b0, 4'hF, 32'h10, 32'h0);
    mid();
    n_cmp++; if (p0.gnt !== 1'b1) begin n_bad++; $display("FAIL rd_gnt: got %b want 1", p0.gnt); end
    n_cmp++; if (p0.rvalid !== 1'b1 || p0.rdata !== 32'h0) begin n_bad++; $display("FAIL wr_resp: got v=%b d=%h want v=1 d=0", p0.rvalid, p0.rdata); end
    step();
    r0 = '0;
    mid();
    n_cmp++; if (p0.rvalid !== 1'b1 || p0.rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL raw_read: got v=%b d=%h want v=1 d=deadbeef", p0.rvalid, p0.rdata); end
    step();
    mid();
    n_cmp++; if (p0.rvalid !== 1'b0 || p0.rdata !== 32'h0 || b0 !== 1'b0) begin n_bad++; $display("FAIL idle_after: got v=%b d=%h busy=%b want 0/0/0", p0.rvalid, p0.rdata, b0); end
    step();
  endtask

  task automatic test_byte_enables();
    r0 = rq(1'b1, 4'hF, 32'h20, 32'h1122_3344);
    step();
    r0 = rq(1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD);
    step();
    r0 = rq(1'b0, 4'hF, 32'h22, 32'h0);
    step();
    r0 = '0;
    mid();
    n_cmp++; if (p0.rdata !== 32'h11BB_33DD) begin n_bad++; $display("FAIL byte_en: got %h want 11bb33dd", p0.rdata); end
    step();
  endtask

  task automatic test_out_of_window();
    r0 = rq(1'b0, 4'hF, 32'h1000, 32'h0);
    mid();
    n_cmp++; if (p0.gnt !== 1'b1) begin n_bad++; $display("FAIL oow_gnt: got %b want 1", p0.gnt); end
    step();
    r0 = rq(1'b1, 4'hF, 32'h1010, 32'h5555_5555);
    mid();
    n_cmp++; if (p0.rvalid !== 1'b1 || p0.rdata !== 32'hBADC_AB1E) begin n_bad++; $display("FAIL oow_rdata: got v=%b d=%h want v=1 d=badcab1e", p0.rvalid, p0.rdata); end
    n_cmp++; if (e0 !== 16'd1) begin n_bad++; $display("FAIL oow_cnt1: got %0d want 1", e0); end
    step();
    r0 = rq(1'b0, 4'hF, 32'h10, 32'h0);
    mid();
    n_cmp++; if (e0 !== 16'd2) begin n_bad++; $display("FAIL oow_cnt2: got %0d want 2", e0); end
    step();
    r0 = '0;
    mid();
    n_cmp++; if (p0.rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL oow_wr_effect: got %h want deadbeef", p0.rdata); end
    step();
    r0 = rq(1'b1, 4'hF, 32'hFFC, 32'h0F0F_0F0F);
    step();
    r0 = rq(1'b0, 4'hF, 32'hFFC, 32'h0);
    step();
    r0 = '0;
    mid();
    n_cmp++; if (p0.rdata !== 32'h0F0F_0F0F || e0 !== 16'd2) begin n_bad++; $display("FAIL last_word: got d=%h cnt=%0d want 0f0f0f0f/2", p0.rdata, e0); end
    step();
    force u0.err_count_q = 16'hFFFF;
    mid();
    release u0.err_count_q;
    step();
    r0 = rq(1'b0, 4'hF, 32'h2000, 32'h0);
    step();
    r0 = '0;
    mid();
    n_cmp++; if (e0 !== 16'hFFFF) begin n_bad++; $display("FAIL oow_sat: got %h want ffff", e0); end
    step();
  endtask

  task automatic test_wait_states();
    r1 = rq(1'b1, 4'hF, 32'h8, 32'hCAFE_0001);
    mid();
    n_cmp++; if (p1.gnt !== 1'b0) begin n_bad++; $display("FAIL ws_c1: got %b want 0", p1.gnt); end
    step();
    mid();
    n_cmp++; if (p1.gnt !== 1'b0) begin n_bad++; $display("FAIL ws_c2: got %b want 0", p1.gnt); end
    step();
    mid();
    n_cmp++; if (p1.gnt !== 1'b1) begin n_bad++; $display("FAIL ws_c3: got %b want 1", p1.gnt); end
    step();
    r1 = rq(1'b0, 4'hF, 32'h8, 32'h0);
    for (int k = 4; k <= 6; k++) begin
      mid();
      n_cmp++; if (p1.gnt !== (k == 6)) begin n_bad++; $display("FAIL ws_b2b_c%0d: got %b want %b", k, p1.gnt, k == 6); end
      step();
    end
    r1 = '0;
    for (int k = 7; k <= 10; k++) begin
      mid();
      n_cmp++; if (p1.rvalid !== (k == 9)) begin n_bad++; $display("FAIL ws_rvalid_c%0d: got %b want %b", k, p1.rvalid, k == 9); end
      if (k == 9) begin
        n_cmp++; if (p1.rdata !== 32'hCAFE_0001) begin n_bad++; $display("FAIL ws_rdata: got %h want cafe0001", p1.rdata); end
      end
      step();
    end
  endtask

  task automatic test_drop_in_wait();
    int n;
    n = 0;
    r1 = rq(1'b0, 4'hF, 32'h8, 32'h0);
    step();
    step();
    r1 = '0;
    for (int k = 0; k < 6; k++) begin
      mid();
      n_cmp++; if (p1.gnt !== 1'b0 || p1.rvalid !== 1'b0) begin n_bad++; $display("FAIL drop_c%0d: got gnt=%b rvalid=%b want 0/0", k, p1.gnt, p1.rvalid); end
      step();
    end
    r1 = rq(1'b0, 4'hF, 32'h8, 32'h0);
    for (int k = 1; k <= 6 && n == 0; k++) begin
      mid();
      if (p1.gnt) n = k;
      step();
    end
    r1 = '0;
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL drop_regrant: got cycle %0d want 3", n); end
    repeat (4) step();
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 4; w++) begin
      r2 = rq(1'b1, 4'hF, 32'(4 * w), 32'(w));
      mid();
      n_cmp++; if (p2.gnt !== 1'b1) begin n_bad++; $display("FAIL b2b_wgnt%0d: got %b want 1", w, p2.gnt); end
      step();
    end
    r2 = '0;
    repeat (5) step();
    for (int k = 0; k <= 8; k++) begin
      r2 = (k < 4) ? rq(1'b0, 4'hF, 32'(4 * k), 32'h0) : '0;
      mid();
      n_cmp++; if (p2.rvalid !== (k >= 4 && k < 8)) begin n_bad++; $display("FAIL b2b_rvalid%0d: got %b want %b", k, p2.rvalid, k >= 4 && k < 8); end
      if (k >= 4 && k < 8) begin
        n_cmp++; if (p2.rdata !== 32'(k - 4)) begin n_bad++; $display("FAIL b2b_rdata%0d: got %h want %h", k, p2.rdata, 32'(k - 4)); end
      end
      n_cmp++; if (b2 !== (k < 8)) begin n_bad++; $display("FAIL b2b_busy%0d: got %b want %b", k, b2, k < 8); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    r1 = rq(1'b1, 4'hF, 32'h40, 32'h1234_5678);
    for (int k = 1; k <= 6 && n == 0; k++) begin
      mid();
      if (p1.gnt) n = k;
      step();
    end
    r1 = '0;
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL rm_wgnt: got cycle %0d want 3", n); end
    repeat (4) step();
    n = 0;
    r1 = rq(1'b0, 4'hF, 32'h40, 32'h0);
    for (int k = 1; k <= 6 && n == 0; k++) begin
      mid();
      if (p1.gnt) n = k;
      step();
    end
    r1 = '0;
    rst = 1'b1;
    mid();
    n_cmp++; if (p1.rvalid !== 1'b0 || p1.rdata !== 32'h0 || p1.gnt !== 1'b0) begin n_bad++; $display("FAIL rm_resp: got v=%b d=%h g=%b want 0/0/0", p1.rvalid, p1.rdata, p1.gnt); end
    n_cmp++; if (b1 !== 1'b0 || e1 !== 16'h0 || e0 !== 16'h0) begin n_bad++; $display("FAIL rm_misc: got busy=%b e1=%h e0=%h want 0/0/0", b1, e1, e0); end
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      mid();
      n_cmp++; if (p1.rvalid !== 1'b0) begin n_bad++; $display("FAIL rm_late_rvalid%0d: got %b want 0", k, p1.rvalid); end
      step();
    end
    n = 0;
    r1 = rq(1'b0, 4'hF, 32'h40, 32'h0);
    for (int k = 1; k <= 6 && n == 0; k++) begin
      mid();
      if (p1.gnt) n = k;
      step();
    end
    r1 = '0;
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL rm_rgnt: got cycle %0d want 3", n); end
    for (int j = 1; j <= 3; j++) begin
      mid();
      n_cmp++; if (p1.rvalid !== (j == 3)) begin n_bad++; $display("FAIL rm_rvalid%0d: got %b want %b", j, p1.rvalid, j == 3); end
      if (j == 3) begin
        n_cmp++; if (p1.rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL rm_kept: got %h want 12345678", p1.rdata); end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_out_of_window();
    test_wait_states();
    test_drop_in_wait();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
